// File: rtl/qam_frame_sync_if.sv
// Stream-side bundle of the framer: serial bits in, packed symbols and frame status out.
// Master drives the bit stream; slave is the framer.
interface qam_frame_sync_if #(
  parameter int BITS_PER_SYM = 6,
  parameter int HDR_W        = 12
) ();
  localparam int ERR_W = $clog2(HDR_W + 1);

  logic                    enable;
  logic                    data_in;
  logic                    enable_fsm;
  logic                    mapping;
  logic [BITS_PER_SYM-1:0] sym_data;
  logic                    sym_valid;
  logic                    frame_start;
  logic                    frame_done;
  logic [15:0]             frame_count;
  logic [ERR_W-1:0]        hdr_err_bits;

  modport master (
    output enable, data_in,
    input  enable_fsm, mapping, sym_data, sym_valid, frame_start, frame_done,
           frame_count, hdr_err_bits
  );

  modport slave (
    input  enable, data_in,
    output enable_fsm, mapping, sym_data, sym_valid, frame_start, frame_done,
           frame_count, hdr_err_bits
  );
endinterface

// File: rtl/qam_frame_sync.sv
// Sync-word hunt (error tolerant) then MSB-first symbol packing of a fixed-length payload; outputs one cycle after the bit.
// No backpressure: enable=0 freezes all state and suppresses strobes.
module qam_frame_sync #(
  parameter int               HDR_W        = 12,
  parameter logic [HDR_W-1:0] SYNC_WORD    = 12'hB38,
  parameter int               PAYLOAD_BITS = 3072,
  parameter int               BITS_PER_SYM = 6,
  parameter int               MAX_ERR      = 0
) (
  input logic             data_clk,
  input logic             rst_n,
  qam_frame_sync_if.slave bus
);
  localparam int ERR_W = $clog2(HDR_W + 1);
  localparam int CNT_W = $clog2(PAYLOAD_BITS + 1);
  localparam int IDX_W = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;

  if (PAYLOAD_BITS <= 0 || (PAYLOAD_BITS % BITS_PER_SYM) != 0) begin : g_bad_payload
    $fatal(1, "qam_frame_sync: PAYLOAD_BITS must be a nonzero multiple of BITS_PER_SYM");
  end
  if (HDR_W < 2 || HDR_W > 32) begin : g_bad_hdr
    $fatal(1, "qam_frame_sync: HDR_W out of range 2..32");
  end
  if (MAX_ERR < 0 || MAX_ERR > HDR_W / 4) begin : g_bad_err
    $fatal(1, "qam_frame_sync: MAX_ERR out of range 0..HDR_W/4");
  end

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1
  } state_t;

  state_t                  state_q, state_d;
  logic [HDR_W-1:0]        win_q, win_d, win_next, diff;
  logic [ERR_W-1:0]        fill_q, fill_d, err_cnt;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BITS_PER_SYM-1:0] asm_q, asm_d, asm_next;
  logic [BITS_PER_SYM-1:0] sym_data_q, sym_data_d;
  logic                    sym_valid_q, sym_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_done_q, frame_done_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0]        hdr_err_q, hdr_err_d;
  logic                    match;

  // Candidate window including the bit on the wire this cycle
  always_comb begin
    win_next = HDR_W'({win_q, bus.data_in});
    asm_next = BITS_PER_SYM'({asm_q, bus.data_in});
    diff     = win_next ^ SYNC_WORD;
    err_cnt  = '0;
    for (int i = 0; i < HDR_W; i++) begin
      err_cnt = err_cnt + ERR_W'(diff[i]);
    end
    match = (fill_q >= ERR_W'(HDR_W - 1)) && (err_cnt <= ERR_W'(MAX_ERR));
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    fill_d        = fill_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    sym_data_d    = sym_data_q;
    sym_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    hdr_err_d     = hdr_err_q;
    case (state_q)
      HUNT: begin
        if (bus.enable) begin
          win_d  = win_next;
          fill_d = (fill_q == ERR_W'(HDR_W)) ? fill_q : fill_q + 1'b1;
          if (match) begin
            state_d       = PAYLOAD;
            frame_start_d = 1'b1;
            cnt_d         = CNT_W'(PAYLOAD_BITS);
            idx_d         = '0;
            hdr_err_d     = err_cnt;
          end
        end
      end
      PAYLOAD: begin
        if (bus.enable) begin
          asm_d = asm_next;
          cnt_d = cnt_q - 1'b1;
          if (idx_q == IDX_W'(BITS_PER_SYM - 1)) begin
            sym_data_d  = asm_next;
            sym_valid_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          // Last payload bit: the hunt restarts from an empty window
          if (cnt_q == CNT_W'(1)) begin
            state_d      = HUNT;
            frame_done_d = 1'b1;
            frame_cnt_d  = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
            fill_d       = '0;
            win_d        = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      win_q         <= '0;
      fill_q        <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      asm_q         <= '0;
      sym_data_q    <= '0;
      sym_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      hdr_err_q     <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      sym_data_q    <= sym_data_d;
      sym_valid_q   <= sym_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      hdr_err_q     <= hdr_err_d;
    end
  end

  assign bus.enable_fsm   = (state_q == PAYLOAD);
  assign bus.mapping      = (state_q == PAYLOAD);
  assign bus.sym_data     = sym_data_q;
  assign bus.sym_valid    = sym_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_count  = frame_cnt_q;
  assign bus.hdr_err_bits = hdr_err_q;
endmodule

// File: tb/tb_qam_frame_sync.sv
// Bench for qam_frame_sync (HDR_W=12, sync 0xB38, 18-bit payload, 6-bit symbols, MAX_ERR=1)
// against a stream-level reference model of hunt, framing and packing.
module tb_qam_frame_sync;
  localparam int          HDR_W = 12;
  localparam logic [11:0] SYNCV = 12'hB38;
  localparam int          PAY   = 18;
  localparam int          BPS   = 6;
  localparam int          MAXE  = 1;

  logic data_clk = 1'b0;
  logic rst_n    = 1'b0;
  int   vecs = 0;
  int   miss = 0;

  qam_frame_sync_if #(.BITS_PER_SYM(BPS), .HDR_W(HDR_W)) bus ();

  qam_frame_sync #(
    .HDR_W(HDR_W), .SYNC_WORD(SYNCV), .PAYLOAD_BITS(PAY),
    .BITS_PER_SYM(BPS), .MAX_ERR(MAXE)
  ) dut (
    .data_clk(data_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 data_clk = ~data_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Stimulus: one entry per clock cycle
  bit s_bit[$];
  bit s_en[$];
  // Observations after each enabled edge
  logic       o_fs[$], o_sv[$], o_fd[$], o_ef[$];
  logic [5:0] o_sd[$];
  int         gap_bad;
  // Model expectations per enabled bit
  bit e_fs[$], e_sv[$], e_fd[$], e_ef[$];
  int e_sd[$];

  task automatic add_bits(input logic [31:0] v, input int n, input int mode);
    for (int i = n - 1; i >= 0; i--) begin
      if (mode == 2) begin
        while ($urandom_range(3) == 0) begin
          s_bit.push_back(1'($urandom_range(1)));
          s_en.push_back(1'b0);
        end
      end
      s_bit.push_back(v[i]);
      s_en.push_back(1'b1);
      if (mode == 1) begin
        s_bit.push_back(~v[i]);
        s_en.push_back(1'b0);
      end
    end
  endtask

  task automatic drive_stream();
    logic       pef;
    logic [5:0] psd;
    o_fs.delete(); o_sv.delete(); o_fd.delete(); o_ef.delete(); o_sd.delete();
    gap_bad = 0;
    pef = bus.enable_fsm;
    psd = bus.sym_data;
    foreach (s_bit[c]) begin
      bus.enable  = s_en[c];
      bus.data_in = s_bit[c];
      @(posedge data_clk);
      #1;
      if (s_en[c]) begin
        o_fs.push_back(bus.frame_start);
        o_sv.push_back(bus.sym_valid);
        o_fd.push_back(bus.frame_done);
        o_ef.push_back(bus.enable_fsm);
        o_sd.push_back(bus.sym_data);
      end else if (bus.sym_valid || bus.frame_start || bus.frame_done ||
                   bus.enable_fsm !== pef || bus.sym_data !== psd) begin
        gap_bad++;
      end
      if (bus.mapping !== bus.enable_fsm) gap_bad++;
      pef = bus.enable_fsm;
      psd = bus.sym_data;
    end
    bus.enable  = 1'b0;
    bus.data_in = 1'b0;
  endtask

  // Reference: scan enabled bits; lock when the last HDR_W fresh bits are within MAXE
  // of the sync word, then chunk the next PAY bits into BPS-bit MSB-first symbols.
  task automatic build_model(output int frames, output int last_err);
    bit          eb[$];
    logic [11:0] sw;
    int          hs, left, nacc, acc, d, sd;
    bit          in_pl, fs, sv, fd;
    sw = SYNCV;
    e_fs.delete(); e_sv.delete(); e_fd.delete(); e_ef.delete(); e_sd.delete();
    frames = 0; last_err = 0; hs = 0; left = 0; nacc = 0; acc = 0; in_pl = 0;
    foreach (s_bit[c]) if (s_en[c]) eb.push_back(s_bit[c]);
    foreach (eb[i]) begin
      fs = 0; sv = 0; fd = 0; sd = 0;
      if (!in_pl) begin
        if (i - hs + 1 >= HDR_W) begin
          d = 0;
          for (int j = 0; j < HDR_W; j++) if (eb[i - HDR_W + 1 + j] != sw[HDR_W - 1 - j]) d++;
          if (d <= MAXE) begin
            fs = 1; in_pl = 1; left = PAY; nacc = 0; acc = 0; last_err = d;
          end
        end
      end else begin
        acc = acc * 2 + int'(eb[i]);
        nacc++;
        left--;
        if (nacc == BPS) begin sv = 1; sd = acc; acc = 0; nacc = 0; end
        if (left == 0) begin fd = 1; in_pl = 0; hs = i + 1; frames++; end
      end
      e_fs.push_back(fs); e_sv.push_back(sv); e_fd.push_back(fd);
      e_sd.push_back(sd); e_ef.push_back(in_pl);
    end
  endtask

  task automatic do_reset();
    bus.enable = 1'b0; bus.data_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);
    rst_n = 1'b1;
    @(posedge data_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b1;
    repeat (4) begin
      bus.data_in = 1'($urandom_range(1));
      @(posedge data_clk);
    end
    #1;
    vecs++;
    if ({bus.enable_fsm, bus.mapping, bus.sym_valid, bus.frame_start, bus.frame_done} !== 5'b0) begin
      miss++; $display("FAIL reset_flags: got %b, required 00000",
                       {bus.enable_fsm, bus.mapping, bus.sym_valid, bus.frame_start, bus.frame_done});
    end
    vecs++;
    if (bus.sym_data !== 6'h0 || bus.hdr_err_bits !== 4'h0) begin
      miss++; $display("FAIL reset_data: sym_data=%h hdr_err=%h, required 0/0", bus.sym_data, bus.hdr_err_bits);
    end
    vecs++;
    if (bus.frame_count !== 16'h0) begin
      miss++; $display("FAIL reset_count: got %h, required 0000", bus.frame_count);
    end
    do_reset();
  endtask

  task automatic test_header_lock();
    int nfs;
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 0);
    add_bits(32'h5, 3, 0);
    drive_stream();
    nfs = 0;
    foreach (o_fs[i]) nfs += int'(o_fs[i]);
    vecs++;
    if (o_fs[11] !== 1'b1 || nfs != 1) begin
      miss++; $display("FAIL lock_start: fs@11=%b count=%0d, required 1 and 1", o_fs[11], nfs);
    end
    vecs++;
    if (o_ef[10] !== 1'b0 || o_ef[11] !== 1'b1 || bus.mapping !== 1'b1) begin
      miss++; $display("FAIL lock_state: ef@10=%b ef@11=%b mapping=%b, required 0 1 1", o_ef[10], o_ef[11], bus.mapping);
    end
    vecs++;
    if (bus.hdr_err_bits !== 4'd0) begin
      miss++; $display("FAIL lock_err: got %0d, required 0", bus.hdr_err_bits);
    end
  endtask

  task automatic test_payload_packing();
    int fr, er;
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 0);
    add_bits(32'b101010_110011_000111, 18, 0);
    add_bits(32'h0, 4, 0);
    drive_stream();
    build_model(fr, er);
    vecs++;
    if (o_sv[17] !== 1'b1 || o_sd[17] !== 6'h2A || o_sv[23] !== 1'b1 || o_sd[23] !== 6'h33) begin
      miss++; $display("FAIL pack_sym12: got %b/%h %b/%h, required 1/2a 1/33", o_sv[17], o_sd[17], o_sv[23], o_sd[23]);
    end
    vecs++;
    if (o_sv[29] !== 1'b1 || o_sd[29] !== 6'h07 || o_fd[29] !== 1'b1 || o_ef[29] !== 1'b0) begin
      miss++; $display("FAIL pack_last: sv=%b sd=%h fd=%b ef=%b, required 1 07 1 0", o_sv[29], o_sd[29], o_fd[29], o_ef[29]);
    end
    vecs++;
    if (bus.frame_count !== 16'd1) begin
      miss++; $display("FAIL pack_count: got %0d, required 1", bus.frame_count);
    end
    foreach (e_fs[i]) begin
      vecs++;
      if ({o_fs[i], o_sv[i], o_fd[i], o_ef[i]} !== {e_fs[i], e_sv[i], e_fd[i], e_ef[i]} ||
          (e_sv[i] && o_sd[i] !== 6'(e_sd[i]))) begin
        miss++; $display("FAIL pack_model bit %0d: fs/sv/fd/ef=%b%b%b%b sd=%h, required %b%b%b%b sd=%h", i,
                         o_fs[i], o_sv[i], o_fd[i], o_ef[i], o_sd[i], e_fs[i], e_sv[i], e_fd[i], e_ef[i], e_sd[i]);
      end
    end
  endtask

  task automatic test_err_tolerance();
    int nfs;
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB39, 12, 0);
    drive_stream();
    vecs++;
    if (o_fs[11] !== 1'b1 || bus.hdr_err_bits !== 4'd1) begin
      miss++; $display("FAIL err1_lock: fs=%b hdr_err=%0d, required 1 and 1", o_fs[11], bus.hdr_err_bits);
    end
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB3B, 12, 0);
    drive_stream();
    nfs = 0;
    foreach (o_fs[i]) nfs += int'(o_fs[i]);
    vecs++;
    if (nfs != 0 || bus.enable_fsm !== 1'b0 || bus.hdr_err_bits !== 4'd0) begin
      miss++; $display("FAIL err2_nolock: starts=%0d ef=%b hdr_err=%0d, required 0 0 0", nfs, bus.enable_fsm, bus.hdr_err_bits);
    end
  endtask

  task automatic test_enable_gaps();
    int   fr, er;
    logic [5:0] syms[$];
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 1);
    add_bits(32'b101010_110011_000111, 18, 1);
    drive_stream();
    build_model(fr, er);
    foreach (o_sv[i]) if (o_sv[i]) syms.push_back(o_sd[i]);
    vecs++;
    if (syms.size() != 3 || syms[0] !== 6'h2A || syms[1] !== 6'h33 || syms[2] !== 6'h07) begin
      miss++; $display("FAIL gap_symbols: got %0d symbols, required 3 (2a 33 07)", syms.size());
    end
    vecs++;
    if (gap_bad != 0 || bus.frame_count !== 16'd1) begin
      miss++; $display("FAIL gap_idle: idle-cycle anomalies=%0d count=%0d, required 0 and 1", gap_bad, bus.frame_count);
    end
    foreach (e_fs[i]) begin
      vecs++;
      if ({o_fs[i], o_sv[i], o_fd[i], o_ef[i]} !== {e_fs[i], e_sv[i], e_fd[i], e_ef[i]} ||
          (e_sv[i] && o_sd[i] !== 6'(e_sd[i]))) begin
        miss++; $display("FAIL gap_model bit %0d: fs/sv/fd/ef=%b%b%b%b sd=%h, required %b%b%b%b sd=%h", i,
                         o_fs[i], o_sv[i], o_fd[i], o_ef[i], o_sd[i], e_fs[i], e_sv[i], e_fd[i], e_ef[i], e_sd[i]);
      end
    end
  endtask

  task automatic test_reset_mid_payload();
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 0);
    add_bits(32'b1010101, 7, 0);
    drive_stream();
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.enable_fsm, bus.mapping, bus.sym_valid, bus.frame_done} !== 4'b0 ||
        bus.sym_data !== 6'h0 || bus.frame_count !== 16'h0) begin
      miss++; $display("FAIL abort_outputs: ef/map/sv/fd=%b sd=%h count=%0d, required 0000 00 0",
                       {bus.enable_fsm, bus.mapping, bus.sym_valid, bus.frame_done}, bus.sym_data, bus.frame_count);
    end
    @(negedge data_clk);
    rst_n = 1'b1;
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 0);
    add_bits(32'b111000_010101_000111, 18, 0);
    drive_stream();
    vecs++;
    if (o_fs[11] !== 1'b1 || o_fd[29] !== 1'b1 || o_sd[17] !== 6'h38 || o_sd[29] !== 6'h07 || bus.frame_count !== 16'd1) begin
      miss++; $display("FAIL abort_relock: fs=%b fd=%b sd=%h/%h count=%0d, required 1 1 38/07 1",
                       o_fs[11], o_fd[29], o_sd[17], o_sd[29], bus.frame_count);
    end
  endtask

  task automatic test_back_to_back();
    int fr, er, nfs;
    do_reset();
    s_bit.delete(); s_en.delete();
    add_bits(32'hB38, 12, 0);
    add_bits({14'b0, 3'b101, 12'hB38, 3'b011}, 18, 0);
    add_bits(32'hB38, 12, 0);
    add_bits($urandom, 18, 0);
    drive_stream();
    build_model(fr, er);
    nfs = 0;
    foreach (o_fs[i]) nfs += int'(o_fs[i]);
    vecs++;
    if (nfs != 2 || o_fs[41] !== 1'b1 || bus.frame_count !== 16'd2) begin
      miss++; $display("FAIL b2b_frames: starts=%0d fs@41=%b count=%0d, required 2 1 2", nfs, o_fs[41], bus.frame_count);
    end
    foreach (e_fs[i]) begin
      vecs++;
      if ({o_fs[i], o_sv[i], o_fd[i], o_ef[i]} !== {e_fs[i], e_sv[i], e_fd[i], e_ef[i]} ||
          (e_sv[i] && o_sd[i] !== 6'(e_sd[i]))) begin
        miss++; $display("FAIL b2b_model bit %0d: fs/sv/fd/ef=%b%b%b%b sd=%h, required %b%b%b%b sd=%h", i,
                         o_fs[i], o_sv[i], o_fd[i], o_ef[i], o_sd[i], e_fs[i], e_sv[i], e_fd[i], e_ef[i], e_sd[i]);
      end
    end
  endtask

  task automatic test_random_hunt();
    int fr, er;
    do_reset();
    s_bit.delete(); s_en.delete();
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(99) == 0) begin
        add_bits(32'hB38, 12, 2);
        add_bits($urandom, 18, 2);
      end
      add_bits(32'($urandom_range(1)), 1, 2);
    end
    drive_stream();
    build_model(fr, er);
    foreach (e_fs[i]) begin
      vecs++;
      if ({o_fs[i], o_sv[i], o_fd[i], o_ef[i]} !== {e_fs[i], e_sv[i], e_fd[i], e_ef[i]} ||
          (e_sv[i] && o_sd[i] !== 6'(e_sd[i]))) begin
        miss++; $display("FAIL rand_model bit %0d: fs/sv/fd/ef=%b%b%b%b sd=%h, required %b%b%b%b sd=%h", i,
                         o_fs[i], o_sv[i], o_fd[i], o_ef[i], o_sd[i], e_fs[i], e_sv[i], e_fd[i], e_ef[i], e_sd[i]);
      end
    end
    vecs++;
    if (bus.frame_count !== 16'(fr) || bus.hdr_err_bits !== 4'(er) || gap_bad != 0) begin
      miss++; $display("FAIL rand_status: count=%0d hdr_err=%0d anomalies=%0d, required %0d %0d 0",
                       bus.frame_count, bus.hdr_err_bits, gap_bad, fr, er);
    end
  endtask

  task automatic test_frame_count_sat();
    do_reset();
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    for (int f = 0; f < 2; f++) begin
      s_bit.delete(); s_en.delete();
      add_bits(32'hB38, 12, 0);
      add_bits($urandom, 18, 0);
      drive_stream();
      vecs++;
      if (bus.frame_count !== 16'hFFFF) begin
        miss++; $display("FAIL sat_count frame %0d: got %h, required ffff", f, bus.frame_count);
      end
    end
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.data_in = 1'b0;
    test_reset();
    test_header_lock();
    test_payload_packing();
    test_err_tolerance();
    test_enable_gaps();
    test_reset_mid_payload();
    test_back_to_back();
    test_random_hunt();
    test_frame_count_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
